pipe_lzc_normalize: RTL
=======================

// Module: pipe_lzc_normalize
// PURPOSE
//  Normalisation stage directly downstream of pipe_lzc. Takes a raw operand plus a biased exponent, pairs it with the
//  leading-zero count that pipe_lzc produces LZC_LATENCY cycles later, and left-shifts the operand so the MSB is set.
//  The shift is clamped to the exponent, which yields a denormal result instead of a negative exponent.
//  Fully pipelined, one beat per clock, no back-pressure. Used in float pack/normalise paths.
// PARAMETERS
//  SIZE         64                         operand width; must equal the SIZE of the companion pipe_lzc
//  OUT_SIZE     $clog2(SIZE+1)             lzc width
//  EXP_W        11                         biased exponent width
//  LZC_LATENCY  pipe_lzc_pkg::lzc_lat(SIZE) pipe_lzc latency; (SIZE<7)?1:($clog2(SIZE-2)+1)/2, which is 3 for SIZE=64
//  SH_STAGES    (OUT_SIZE+1)/2             shifter pipeline stages, 2 shift bits each; 4 for SIZE=64
// PORTS
//  clk        in   1         clock
//  rst_n      in   1         asynchronous reset, active-low
//  din        in   SIZE      raw operand; the same value is driven on pipe_lzc.din in the same cycle
//  exp_in     in   EXP_W     biased exponent of din, unsigned
//  valid_in   in   1         din/exp_in qualifier
//  lzc        in   OUT_SIZE  pipe_lzc.dout; corresponds to the din presented LZC_LATENCY cycles earlier
//  dout       out  SIZE      normalised operand
//  exp_out    out  EXP_W     adjusted exponent
//  zero       out  1         din was all zeros
//  denorm     out  1         shift clamped by the exponent (lzc > exp_in)
//  valid_out  out  1         output qualifier
// BEHAVIOUR
//  - Latency: a beat accepted at cycle t appears at t + LZC_LATENCY + 1 + SH_STAGES, which is 8 for the defaults. Constant; bubbles are preserved.
//  - Alignment: din, exp_in and valid_in pass through an LZC_LATENCY-deep delay line. lzc carries no valid; it is sampled
//    when the delayed valid is high and ignored otherwise.
//  - Clamp stage (1 register):
//    - iszero = (lzc == SIZE)
//    - shamt  = (lzc > exp_in) ? exp_in : lzc, compared at max(OUT_SIZE, EXP_W) bits zero-extended
//    - exp_out = exp_in - shamt, which never underflows
//    - denorm = !iszero && (lzc > exp_in)
//  - Shifter: stage k shifts left by shamt[2k+1:2k] × 4^k and zero-fills. The residual shamt and flags travel alongside.
//    Total shift never exceeds SIZE-1 except when iszero.
//  - Zero override: if iszero, then dout=0, exp_out=0, zero=1, denorm=0, regardless of exp_in.
//  - Non-valid beats: data/exp registers may hold don't-care values. valid_out=0. A bench checks outputs only when valid_out=1.
//  - Reset: while rst_n=0, all valid bits, dout, exp_out, zero, denorm and valid_out are 0.
//    - Asserting rst_n mid-flight drops every in-flight beat.
//    - After release, valid_out stays 0 until the first beat accepted post-reset reaches the output.
//    - pipe_lzc has no reset. Any stale lzc value is masked because the aligned valid is 0.
//  - Data-path registers other than valid/output may be reset-free for area. Only the items listed above are reset.
//  - Back-to-back beats with no bubbles are sustained indefinitely. There is no stall input.
// STRUCTURE
//  - pipe_lzc_pkg:
//    - function lzc_lat(SIZE) holds the latency formula shared with pipe_lzc and its bench
//    - function lzc_out_size(SIZE)
//    - typedef for the shifter stage bundle {data, exp, shamt_rem, zero, denorm, valid}
//  - Sub-module pipe_lzc_shstage #(SIZE, OUT_SIZE, K): one registered 2-bit shift stage.
//    Instantiated SH_STAGES times in a generate loop; the last stage drops its unused high shift bit when OUT_SIZE is odd.
//  - The delay line and clamp stage are inline.
//  - pipe_lzc is NOT instantiated here; the integrator connects pipe_lzc.dout to the lzc port.
// TESTING
//  - Bench instantiates pipe_lzc alongside the DUT, sweeps SIZE 6..66 as the pipe_lzc bench does, and uses SIZE=64 / EXP_W=11 below.
//  - din=64'h1, exp_in=100 -> 8 cycles later: dout=64'h8000_0000_0000_0000, exp_out=37, zero=0, denorm=0.
//  - din=64'h1, exp_in=10 -> dout=64'h400, exp_out=0, denorm=1, zero=0.
//  - din=0, exp_in=500 -> dout=0, exp_out=0, zero=1, denorm=0.
//  - din=64'h8000_0000_0000_0001, exp_in=0 -> dout unchanged, exp_out=0, denorm=0.
//  - 1000 random beats with about 30% valid_in bubbles, against a behavioural model:
//    - valid_out pattern equals valid_in delayed by 8
//    - every valid output matches the model
//  - Pulse rst_n low for 2 cycles while 5 beats are in flight:
//    - no valid_out for those beats
//    - outputs 0 during reset
//    - the next accepted beat emerges exactly 8 cycles after its acceptance

Source files
------------

// File: rtl/pipe_lzc_pkg.sv
// Shared definitions for pipe_lzc and its downstream normalisation stage.
//   lzc_lat(size)      : pipeline latency of pipe_lzc for a given operand width
//   lzc_out_size(size) : width of the leading-zero count
//   sh_bundle_t        : one shifter-stage payload at the default widths
//                        (SIZE=64, EXP_W=11); also serves as a scoreboard entry
package pipe_lzc_pkg;

  function automatic int lzc_lat(input int size);
    return (size < 7) ? 1 : ($clog2(size - 2) + 1) / 2;
  endfunction

  function automatic int lzc_out_size(input int size);
    return $clog2(size + 1);
  endfunction

  localparam int DEF_SIZE     = 64;
  localparam int DEF_EXP_W    = 11;
  localparam int DEF_OUT_SIZE = lzc_out_size(DEF_SIZE);

  typedef struct packed {
    logic [DEF_SIZE-1:0]     data;
    logic [DEF_EXP_W-1:0]    expo;
    logic [DEF_OUT_SIZE-1:0] shamt_rem;
    logic                    zero;
    logic                    denorm;
    logic                    valid;
  } sh_bundle_t;

endpackage

// File: rtl/pipe_lzc_shstage.sv
// One registered stage of the normalising left shifter.
// Stage K shifts by shamt_in[2K+1:2K] * 4^K with zero fill and clears those
// bits from the residual shift amount it forwards. When OUT_SIZE is odd the
// mask for the last stage naturally drops the non-existent high bit.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   data_in/exp_in/shamt_in     payload from the previous stage
//   zero_in/denorm_in/valid_in  flags from the previous stage
//   *_out                       registered payload/flags for the next stage
// RST_DATA=1 resets the payload and flags as well as valid (used on the
// output stage so the block outputs read 0 during reset).
module pipe_lzc_shstage
  import pipe_lzc_pkg::*;
#(
  parameter int SIZE     = 64,
  parameter int OUT_SIZE = 7,
  parameter int EXP_W    = 11,
  parameter int K        = 0,
  parameter bit RST_DATA = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SIZE-1:0]     data_in,
  input  logic [EXP_W-1:0]    exp_in,
  input  logic [OUT_SIZE-1:0] shamt_in,
  input  logic                zero_in,
  input  logic                denorm_in,
  input  logic                valid_in,
  output logic [SIZE-1:0]     data_out,
  output logic [EXP_W-1:0]    exp_out,
  output logic [OUT_SIZE-1:0] shamt_out,
  output logic                zero_out,
  output logic                denorm_out,
  output logic                valid_out
);

  localparam logic [OUT_SIZE-1:0] STEP_MASK = OUT_SIZE'(3) << (2 * K);

  logic [OUT_SIZE-1:0] step_amt;
  logic [SIZE-1:0]     data_sh;

  // Masking keeps the shift at a multiple of 4^K without slicing the amount.
  assign step_amt = shamt_in & STEP_MASK;
  assign data_sh  = data_in << step_amt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_out <= 1'b0;
    else        valid_out <= valid_in;
  end

  if (RST_DATA) begin : g_rst
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_out   <= '0;
        exp_out    <= '0;
        shamt_out  <= '0;
        zero_out   <= 1'b0;
        denorm_out <= 1'b0;
      end else begin
        data_out   <= data_sh;
        exp_out    <= exp_in;
        shamt_out  <= shamt_in & ~STEP_MASK;
        zero_out   <= zero_in;
        denorm_out <= denorm_in;
      end
    end
  end else begin : g_nrst
    always_ff @(posedge clk) begin
      data_out   <= data_sh;
      exp_out    <= exp_in;
      shamt_out  <= shamt_in & ~STEP_MASK;
      zero_out   <= zero_in;
      denorm_out <= denorm_in;
    end
  end

endmodule

// File: rtl/pipe_lzc_normalize.sv
// Normalisation stage downstream of pipe_lzc.
// The operand and exponent are delayed LZC_LATENCY cycles so they line up with
// the leading-zero count from pipe_lzc, the shift is clamped to the exponent
// (giving a denormal instead of a negative exponent), and a 2-bit-per-stage
// pipelined shifter moves the leading one to the MSB.
// Latency LZC_LATENCY + 1 + SH_STAGES, one beat per clock, no back-pressure.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   din          raw operand (same value driven into pipe_lzc this cycle)
//   exp_in       biased exponent of din
//   valid_in     din/exp_in qualifier
//   lzc          pipe_lzc result for the din given LZC_LATENCY cycles earlier
//   dout         normalised operand
//   exp_out      adjusted exponent
//   zero         operand was all zeros
//   denorm       shift was clamped by the exponent
//   valid_out    output qualifier
module pipe_lzc_normalize
  import pipe_lzc_pkg::*;
#(
  parameter int SIZE        = 64,
  parameter int OUT_SIZE    = lzc_out_size(SIZE),
  parameter int EXP_W       = 11,
  parameter int LZC_LATENCY = lzc_lat(SIZE),
  parameter int SH_STAGES   = (OUT_SIZE + 1) / 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SIZE-1:0]     din,
  input  logic [EXP_W-1:0]    exp_in,
  input  logic                valid_in,
  input  logic [OUT_SIZE-1:0] lzc,
  output logic [SIZE-1:0]     dout,
  output logic [EXP_W-1:0]    exp_out,
  output logic                zero,
  output logic                denorm,
  output logic                valid_out
);

  localparam int CMP_W = (OUT_SIZE > EXP_W) ? OUT_SIZE : EXP_W;

  // ---------------------------------------------------------------- delay line
  logic [SIZE-1:0]        dl_din [LZC_LATENCY];
  logic [EXP_W-1:0]       dl_exp [LZC_LATENCY];
  logic [LZC_LATENCY-1:0] dl_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_valid <= '0;
    end else begin
      dl_valid[0] <= valid_in;
      for (int i = 1; i < LZC_LATENCY; i++) dl_valid[i] <= dl_valid[i-1];
    end
  end

  always_ff @(posedge clk) begin
    dl_din[0] <= din;
    dl_exp[0] <= exp_in;
    for (int i = 1; i < LZC_LATENCY; i++) begin
      dl_din[i] <= dl_din[i-1];
      dl_exp[i] <= dl_exp[i-1];
    end
  end

  // --------------------------------------------------------------- clamp stage
  logic [SIZE-1:0]     al_din;
  logic [EXP_W-1:0]    al_exp;
  logic                al_valid;
  logic [CMP_W-1:0]    lzc_c;
  logic [CMP_W-1:0]    exp_c;
  logic                is_zero;
  logic                over;
  logic [OUT_SIZE-1:0] shamt_d;
  logic [EXP_W-1:0]    exp_adj_d;

  assign al_din   = dl_din[LZC_LATENCY-1];
  assign al_exp   = dl_exp[LZC_LATENCY-1];
  assign al_valid = dl_valid[LZC_LATENCY-1];

  assign lzc_c   = CMP_W'(lzc);
  assign exp_c   = CMP_W'(al_exp);
  assign is_zero = (lzc_c == CMP_W'(SIZE));
  assign over    = (lzc_c > exp_c);

  // When clamped, shamt = exp_in < lzc <= SIZE, so it fits OUT_SIZE bits and
  // the subtraction below cannot underflow.
  assign shamt_d   = is_zero ? '0 : (over ? OUT_SIZE'(al_exp) : lzc);
  assign exp_adj_d = is_zero ? '0 : al_exp - EXP_W'(shamt_d);

  logic                cl_valid;
  logic [SIZE-1:0]     cl_data;
  logic [EXP_W-1:0]    cl_exp;
  logic [OUT_SIZE-1:0] cl_shamt;
  logic                cl_zero;
  logic                cl_denorm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cl_valid <= 1'b0;
    else        cl_valid <= al_valid;
  end

  // lzc has no qualifier and pipe_lzc is not reset, so it is only looked at
  // when the aligned valid is high.
  always_ff @(posedge clk) begin
    if (al_valid) begin
      cl_data   <= is_zero ? '0 : al_din;
      cl_exp    <= exp_adj_d;
      cl_shamt  <= shamt_d;
      cl_zero   <= is_zero;
      cl_denorm <= over && !is_zero;
    end
  end

  // ------------------------------------------------------------------ shifter
  logic [SIZE-1:0]     st_data   [SH_STAGES];
  logic [EXP_W-1:0]    st_exp    [SH_STAGES];
  logic [OUT_SIZE-1:0] st_shamt  [SH_STAGES];
  logic                st_zero   [SH_STAGES];
  logic                st_denorm [SH_STAGES];
  logic                st_valid  [SH_STAGES];

  for (genvar k = 0; k < SH_STAGES; k++) begin : g_sh
    logic [SIZE-1:0]     d_i;
    logic [EXP_W-1:0]    e_i;
    logic [OUT_SIZE-1:0] s_i;
    logic                z_i;
    logic                dn_i;
    logic                v_i;

    if (k == 0) begin : g_first
      assign d_i  = cl_data;
      assign e_i  = cl_exp;
      assign s_i  = cl_shamt;
      assign z_i  = cl_zero;
      assign dn_i = cl_denorm;
      assign v_i  = cl_valid;
    end else begin : g_next
      assign d_i  = st_data[k-1];
      assign e_i  = st_exp[k-1];
      assign s_i  = st_shamt[k-1];
      assign z_i  = st_zero[k-1];
      assign dn_i = st_denorm[k-1];
      assign v_i  = st_valid[k-1];
    end

    pipe_lzc_shstage #(
      .SIZE     (SIZE),
      .OUT_SIZE (OUT_SIZE),
      .EXP_W    (EXP_W),
      .K        (k),
      .RST_DATA (k == SH_STAGES - 1)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (d_i),
      .exp_in     (e_i),
      .shamt_in   (s_i),
      .zero_in    (z_i),
      .denorm_in  (dn_i),
      .valid_in   (v_i),
      .data_out   (st_data[k]),
      .exp_out    (st_exp[k]),
      .shamt_out  (st_shamt[k]),
      .zero_out   (st_zero[k]),
      .denorm_out (st_denorm[k]),
      .valid_out  (st_valid[k])
    );
  end

  // The residual shift amount is fully consumed by the last stage.
  logic [OUT_SIZE-1:0] unused_shamt;
  assign unused_shamt = st_shamt[SH_STAGES-1];

  assign dout      = st_data[SH_STAGES-1];
  assign exp_out   = st_exp[SH_STAGES-1];
  assign zero      = st_zero[SH_STAGES-1];
  assign denorm    = st_denorm[SH_STAGES-1];
  assign valid_out = st_valid[SH_STAGES-1];

endmodule
